// File: rtl/generador_estimulos_pkg.sv
// Shared definitions for the shift-register comparison bench: FSM states, MODO codes, LFSR polynomial.
// No logic; lfsr_step is the single-step Galois update used by the generator.
// MODO codes are shared with the shift-register modules under test.
package generador_estimulos_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHL   = 3'd2,
        SHR   = 3'd3,
        HOLD  = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } estado_t;

    localparam logic [1:0] MODO_HOLD = 2'b00;
    localparam logic [1:0] MODO_SHL  = 2'b01;
    localparam logic [1:0] MODO_SHR  = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/generador_estimulos_lfsr32.sv
// 32-bit Galois LFSR holding the parallel-load data sequence; reloadable to SEED.
// Latency: new value visible the cycle after en/ld_seed.
// Backpressure: none; ld_seed has priority over en.
module generador_estimulos_lfsr32
    import generador_estimulos_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE12468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ld_seed,
    output logic [31:0] estado
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (ld_seed) begin
            lfsr_d = SEED;
        end else if (en) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign estado = lfsr_q;

endmodule

// File: rtl/generador_estimulos.sv
// Stimulus generator / ALERTA tally for the shift-register bench; PARADA_EN_ERROR_EN stops at first mismatch.
// Latency: all outputs registered with the state; ALERTA is scored CHK_DLY cycles after its stimulus.
// Backpressure: none; START is ignored while a run is in progress.
module generador_estimulos
    import generador_estimulos_pkg::*;
#(
    parameter int          N_VECT  = 8,
    parameter int          N_SHIFT = 4,
    parameter logic [31:0] SEED    = 32'hACE12468,
    parameter int          CHK_DLY = 1,
    parameter int          ERR_W   = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ALERTA,
    output logic [1:0]       MODO,
    output logic [31:0]      D,
    output logic             S_IN,
    output logic             OCUPADO,
    output logic             FIN,
    output logic [ERR_W-1:0] ERRORES,
    output logic [7:0]       VEC_ACT
);

    estado_t              estado_q, estado_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [7:0]           vec_q, vec_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [1:0]           modo_q, modo_d;
    logic [31:0]          dat_q, dat_d;
    logic                 s_in_q, s_in_d;
    logic                 ocupado_q, ocupado_d;
    logic                 fin_q, fin_d;
    logic [CHK_DLY-1:0]   vld_pipe_q, vld_pipe_d;

    logic [31:0] lfsr;
    logic [31:0] lfsr_vista;
    logic        lfsr_en;
    logic        lfsr_ld;
    logic        vld_ahora;
    logic        acierto;

    generador_estimulos_lfsr32 #(.SEED(SEED)) u_lfsr32 (
        .clk     (CLK),
        .rst     (RESET),
        .en      (lfsr_en),
        .ld_seed (lfsr_ld),
        .estado  (lfsr)
    );

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q + 5'd1;
        vec_d      = vec_q;
        err_d      = err_q;
        lfsr_en    = 1'b0;
        lfsr_ld    = 1'b0;
        vld_ahora  = estado_q inside {LOAD, SHL, SHR, HOLD};
        acierto    = vld_pipe_q[CHK_DLY-1] && ALERTA;

        if (acierto && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end

        case (estado_q)
            IDLE, DONE: begin
                if (START) begin
                    estado_d = LOAD;
                    cnt_d    = 5'd0;
                    vec_d    = 8'd0;
                    err_d    = '0;
                    lfsr_ld  = 1'b1;
                end
            end
            LOAD: begin
                estado_d = SHL;
                cnt_d    = 5'd0;
                lfsr_en  = 1'b1;
            end
            SHL: begin
                if (cnt_q == 5'(N_SHIFT - 1)) begin
                    estado_d = SHR;
                    cnt_d    = 5'd0;
                end
            end
            SHR: begin
                if (cnt_q == 5'(N_SHIFT - 1)) begin
                    estado_d = HOLD;
                    cnt_d    = 5'd0;
                end
            end
            HOLD: begin
                if (cnt_q == 5'd1) begin
                    cnt_d = 5'd0;
                    if (vec_q < 8'(N_VECT - 1)) begin
                        estado_d = LOAD;
                        vec_d    = vec_q + 8'd1;
                    end else begin
                        estado_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == 5'(CHK_DLY - 1)) begin
                    estado_d = DONE;
                    cnt_d    = 5'd0;
                end
            end
            default: estado_d = IDLE;
        endcase

`ifdef PARADA_EN_ERROR_EN
        if (acierto) begin
            estado_d = DONE;
            vec_d    = vec_q;
        end
`endif

        // The first SHL cycle already sees the LFSR advanced on leaving LOAD.
        lfsr_vista = (estado_q == LOAD) ? lfsr_step(lfsr) : lfsr;

        case (estado_d)
            LOAD:    modo_d = MODO_LOAD;
            SHL:     modo_d = MODO_SHL;
            SHR:     modo_d = MODO_SHR;
            default: modo_d = MODO_HOLD;
        endcase

        dat_d = dat_q;
        if (estado_d == LOAD) begin
            dat_d = lfsr_ld ? SEED : lfsr;
        end

        s_in_d     = (estado_d inside {SHL, SHR}) ? lfsr_vista[cnt_d] : 1'b0;
        ocupado_d  = estado_d inside {LOAD, SHL, SHR, HOLD, DRAIN};
        fin_d      = (estado_d == DONE);

        vld_pipe_d = (vld_pipe_q << 1) | CHK_DLY'(vld_ahora);
        if (estado_d == DONE) begin
            vld_pipe_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            estado_q   <= IDLE;
            cnt_q      <= 5'd0;
            vec_q      <= 8'd0;
            err_q      <= '0;
            modo_q     <= MODO_HOLD;
            dat_q      <= 32'd0;
            s_in_q     <= 1'b0;
            ocupado_q  <= 1'b0;
            fin_q      <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            err_q      <= err_d;
            modo_q     <= modo_d;
            dat_q      <= dat_d;
            s_in_q     <= s_in_d;
            ocupado_q  <= ocupado_d;
            fin_q      <= fin_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign MODO    = modo_q;
    assign D       = dat_q;
    assign S_IN    = s_in_q;
    assign OCUPADO = ocupado_q;
    assign FIN     = fin_q;
    assign ERRORES = err_q;
    assign VEC_ACT = vec_q;

endmodule

// File: tb/tb_generador_estimulos.sv
// Bench for generador_estimulos: expected per-cycle trace built from the run rules, compared every cycle.
module tb_generador_estimulos;

    localparam int          NV     = 8;
    localparam int          NS     = 4;
    localparam int          CD     = 1;
    localparam logic [31:0] SEED   = 32'hACE12468;
    localparam int          VLEN   = 1 + 2 * NS + 2;
    localparam int          ACTIVE = NV * VLEN;
    localparam int          T_DONE = ACTIVE + CD;

    logic        clk = 1'b0;
    logic        rst, start, alerta, alerta4;
    logic [1:0]  modo, modo4;
    logic [31:0] d, d4;
    logic        s_in, s_in4, ocup, ocup4, fin, fin4;
    logic [7:0]  err, vec, vec4;
    logic [3:0]  err4;

    int checks = 0;
    int errors = 0;

    logic [1:0]  e_modo [0:T_DONE];
    logic [31:0] e_d    [0:T_DONE];
    logic        e_sin  [0:T_DONE];
    int          e_vec  [0:T_DONE];

    generador_estimulos dut (
        .CLK(clk), .RESET(rst), .START(start), .ALERTA(alerta),
        .MODO(modo), .D(d), .S_IN(s_in), .OCUPADO(ocup), .FIN(fin),
        .ERRORES(err), .VEC_ACT(vec)
    );

    generador_estimulos #(.ERR_W(4)) dut4 (
        .CLK(clk), .RESET(rst), .START(start), .ALERTA(alerta4),
        .MODO(modo4), .D(d4), .S_IN(s_in4), .OCUPADO(ocup4), .FIN(fin4),
        .ERRORES(err4), .VEC_ACT(vec4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] nxt(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic build_trace();
        logic [31:0] s, a;
        int b;
        s = SEED;
        for (int v = 0; v < NV; v++) begin
            b = v * VLEN;
            a = nxt(s);
            for (int i = 0; i < VLEN; i++) begin
                e_modo[b+i] = 2'b00;
                e_sin[b+i]  = 1'b0;
                e_d[b+i]    = s;
                e_vec[b+i]  = v;
            end
            e_modo[b] = 2'b11;
            for (int i = 0; i < NS; i++) begin
                e_modo[b+1+i]    = 2'b01;
                e_sin[b+1+i]     = a[i];
                e_modo[b+1+NS+i] = 2'b10;
                e_sin[b+1+NS+i]  = a[i];
            end
            s = a;
        end
        for (int t = ACTIVE; t <= T_DONE; t++) begin
            e_modo[t] = 2'b00;
            e_sin[t]  = 1'b0;
            e_d[t]    = 32'd0;
            e_vec[t]  = NV - 1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_modo"}, modo, 2'b00);
        chk({tag, "_d"},    d, 32'd0);
        chk({tag, "_sin"},  s_in, 1'b0);
        chk({tag, "_ocup"}, ocup, 1'b0);
        chk({tag, "_fin"},  fin, 1'b0);
        chk({tag, "_err"},  err, 8'd0);
        chk({tag, "_vec"},  vec, 8'd0);
    endtask

    // mode 0: ALERTA low; 1: three hits in vector 2; 2: random; 3: single hit in vector 5
    task automatic do_run(input int mode, input int start_t, input int rst_t);
        int   cnt;
        bit   stopped;
        int   stop_vec;
        logic a;
        cnt = 0;
        stopped = 0;
        stop_vec = 0;
        start  = 1'b1;
        alerta = (mode == 2);
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t <= T_DONE; t++) begin
            if (stopped) begin
                chk("stop_fin",  fin, 1'b1);
                chk("stop_ocup", ocup, 1'b0);
                chk("stop_modo", modo, 2'b00);
                chk("stop_err",  err, 8'(cnt));
                chk("stop_vec",  vec, 8'(stop_vec));
                break;
            end
            chk("modo", modo, e_modo[t]);
            chk("s_in", s_in, e_sin[t]);
            if (e_modo[t] == 2'b11) chk("d_load", d, e_d[t]);
            chk("ocupado", ocup, (t < T_DONE));
            chk("fin", fin, (t == T_DONE));
            chk("vec_act", vec, 8'(e_vec[t]));
            chk("errores", err, 8'(cnt));
            if (t == T_DONE) break;
            case (mode)
                1:       a = (t >= 25 && t <= 27);
                2:       a = ($urandom_range(0, 7) == 0);
                3:       a = (t == 58);
                default: a = 1'b0;
            endcase
            alerta = a;
            start  = (t == start_t);
            rst    = (t == rst_t);
            if (a && t >= CD && t <= ACTIVE - 1 + CD) begin
                if (cnt < 255) cnt++;
`ifdef PARADA_EN_ERROR_EN
                stopped  = 1;
                stop_vec = e_vec[t];
`endif
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (t == rst_t) begin
                rst = 1'b0;
                chk_reset_vals("midrst");
                return;
            end
        end
        alerta = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        alerta  = 1'b0;
        alerta4 = 1'b1;
        build_trace();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("reset");
        chk("reset_err4", err4, 4'd0);
        @(posedge clk); #1;
        chk("idle_ocup", ocup, 1'b0);

        do_run(0, -1, -1);
`ifdef PARADA_EN_ERROR_EN
        chk("err4_sat", err4, 4'h1);
`else
        chk("err4_sat", err4, 4'hF);
`endif
        do_run(1, -1, -1);
        do_run(0, 35, -1);
        do_run(0, -1, 50);
        do_run(0, -1, -1);
        do_run(3, -1, -1);
        for (int r = 0; r < 3; r++) do_run(2, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/generador_estimulos.md
Name: generador_estimulos

Overview:
- Stimulus generator and result collector for the 32-bit shift-register comparison bench.
- Drives mode, parallel data and serial input to both register implementations (structural and behavioural) in parallel.
- Samples the comparator's ALERTA line back and reports an error count and a done flag.
- Closes the loop on the comparator: the comparator observes, this block drives and tallies.

Parameters:
- N_VECT, 8: number of test vectors (load/shift sequences) per run, 1..255.
- N_SHIFT, 4: cycles spent in each shift direction per vector, 1..31.
- SEED, 32'hACE12468: LFSR start value for parallel data; must be nonzero.
- CHK_DLY, 1: cycles between driving a stimulus and ALERTA being valid for it, 1..4.
- ERR_W, 8: width of error counter.

Ports:
- CLK  in  1  bench clock, all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  begin a run; sampled in IDLE or FIN only.
- ALERTA  in  1  mismatch flag from comparator.
- MODO  out  2  register mode: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- D  out  32  parallel load data.
- S_IN  out  1  serial input bit for shifts.
- OCUPADO  out  1  run in progress (LOAD..DRAIN).
- FIN  out  1  run complete, held until START or RESET.
- ERRORES  out  ERR_W  count of sampled mismatches, saturating.
- VEC_ACT  out  8  index of current vector, 0-based.

Behaviour:
- One clock (CLK); synchronous active-high reset (RESET); all outputs are flops.
- Reset values:
  - State IDLE.
  - MODO=00, D=0, S_IN=0, OCUPADO=0, FIN=0, ERRORES=0, VEC_ACT=0.
  - LFSR=SEED, valid pipeline cleared.
- States:
  - IDLE, LOAD, SHL, SHR, HOLD, DRAIN, DONE.
  - Moore outputs are registered on the same edge as the state.
- Transitions:
  - IDLE -START-> LOAD.
  - LOAD (1 cycle, MODO=11, D=LFSR) -> SHL.
  - SHL (N_SHIFT cycles, MODO=01) -> SHR.
  - SHR (N_SHIFT cycles, MODO=10) -> HOLD.
  - HOLD (2 cycles, MODO=00) -> LOAD if VEC_ACT<N_VECT-1, else DRAIN.
  - DRAIN (CHK_DLY cycles, MODO=00) -> DONE.
  - DONE -START-> LOAD (new run).
- Vector length: 1+2*N_SHIFT+2 cycles. Defaults give 11 per vector and 88 active cycles.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003).
  - Advances once on leaving LOAD. First vector loads SEED exactly.
- Serial input:
  - S_IN = LFSR[shift_cnt] during SHL/SHR, where shift_cnt is the in-state cycle index.
  - S_IN = 0 in every other state.
- VEC_ACT: increments on HOLD->LOAD. Cleared on START from DONE.
- Checking:
  - valid=1 while in LOAD/SHL/SHR/HOLD. It is delayed by a CHK_DLY-deep shift pipe.
  - ERRORES increments when the delayed valid=1 and ALERTA=1.
  - ERRORES saturates at all-ones.
  - ALERTA is ignored when the delayed valid=0.
- OCUPADO=1 in LOAD..DRAIN. FIN=1 only in DONE.
- Boundaries:
  - START while OCUPADO: ignored.
  - START in DONE: clears ERRORES and VEC_ACT, reloads LFSR=SEED, clears FIN on the same edge.
  - RESET mid-run: everything returns to reset values on that edge; RESET has priority over START.
  - ALERTA high in the same cycle as a restart edge: not counted.

Optional Feature:
- PARADA_EN_ERROR_EN defined:
  - The first counted mismatch forces the next state to DONE regardless of position, skipping DRAIN.
  - VEC_ACT freezes at the failing vector.
  - ERRORES stays 1.
- PARADA_EN_ERROR_EN undefined: the full run always completes and all mismatches are counted.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..DONE);
  - MODO codes (MODO_HOLD=2'b00, MODO_SHL=2'b01, MODO_SHR=2'b10, MODO_LOAD=2'b11);
  - LFSR_MASK=32'h80200003.
  - The MODO codes are shared with the shift-register modules.
- One sub-module: lfsr32 (enable, load-seed, 32-bit state out).

Test Plan:
- Reset, then START pulse at edge k with defaults and ALERTA tied 0:
  - MODO=11 and D=32'hACE12468 after edge k;
  - OCUPADO high for 89 cycles;
  - FIN rises after edge k+89;
  - ERRORES=0, VEC_ACT=7.
- Same run with ALERTA=1 for 3 valid cycles in vector 2 -> ERRORES=3 at FIN.
- ALERTA held 1 for the whole run with ERR_W=4 -> ERRORES saturates at 4'hF, no wrap.
- START pulsed mid-run at vector 3 -> ignored; FIN timing unchanged. START in DONE -> new run, ERRORES cleared, D=SEED again.
- RESET asserted during SHR of vector 4 -> next cycle MODO=00, OCUPADO=0, ERRORES=0, LFSR=SEED; START afterwards replays an identical sequence.
- PARADA_EN_ERROR_EN defined, single ALERTA pulse (valid) in vector 5 -> FIN=1 within 1 cycle, VEC_ACT=5, ERRORES=1.
